// File: rtl/clint_pkg.sv
// clint_pkg: shared register map, reset constants and bus types for the CLINT timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clint_pkg;

    // Hart count ceiling; hart index width follows from it.
    localparam int unsigned NUM_HARTS_MAX = 16;
    localparam int unsigned HART_W        = $clog2(NUM_HARTS_MAX);

    // Byte offsets of the register windows.
    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    // mtimecmp resets to all-ones so no hart sees a timer interrupt out of reset.
    localparam logic [63:0] MTIMECMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_RSP  = 1'b1
    } bus_state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_MTIME_LO,
        SEL_MTIME_HI
    } sel_e;

endpackage

// File: rtl/clint_hart_cmp.sv
// clint_hart_cmp: per-hart mtimecmp/msip registers and registered mtime >= mtimecmp compare.
// Latency: writes visible next cycle; mtip_o reflects the previous cycle's mtime/mtimecmp.
// Backpressure: none; write strobes are single-cycle qualified accepts from the bus.
// Ports: clk/rst; wr_*_i write strobes with wdata_i; mtime_i current time;
//        mtimecmp_o for the read mux; msip_o/mtip_o interrupt levels.
module clint_hart_cmp
    import clint_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_msip_i,
    input  logic        wr_cmp_lo_i,
    input  logic        wr_cmp_hi_i,
    input  logic [31:0] wdata_i,
    input  logic [63:0] mtime_i,
    output logic [63:0] mtimecmp_o,
    output logic        msip_o,
    output logic        mtip_o
);

    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_cmp_lo_i) mtimecmp_d[31:0]  = wdata_i;
        if (wr_cmp_hi_i) mtimecmp_d[63:32] = wdata_i;
        if (wr_msip_i)   msip_d            = wdata_i[0];
        // Level compare on the current registers; clears as soon as the condition goes away.
        mtip_d = (mtime_i >= mtimecmp_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
        end
    end

    assign mtimecmp_o = mtimecmp_q;
    assign msip_o     = msip_q;
    assign mtip_o     = mtip_q;

endmodule

// File: rtl/clint_mtimer.sv
// clint_mtimer: multi-hart mtime/mtimecmp/msip timer unit on a valid/ready register bus.
// Latency: response 1 cycle after accept; mtip_o lags the mtime/mtimecmp registers by 1 cycle.
// Backpressure: req_ready_o drops while a response is held with rsp_ready_i low.
// Ports: clk/rst (sync, active-high); req_* request; rsp_* response; mtip_o/msip_o per hart; mtime_o.
// Option: define CLINT_MTIME_HALT_EN to add mtime_halt_i, which freezes mtime and the prescaler.
module clint_mtimer
    import clint_pkg::*;
#(
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [31:0]          req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
`ifdef CLINT_MTIME_HALT_EN
    input  logic                 mtime_halt_i,
`endif
    output logic [NUM_HARTS-1:0] mtip_o,
    output logic [NUM_HARTS-1:0] msip_o,
    output logic [63:0]          mtime_o
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic [63:0]      mtime_q, mtime_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    bus_state_e       state_q, state_d;
    rsp_t             rsp_q, rsp_d;

    logic              halt;
    logic              accept, wr_ok;
    sel_e              sel;
    logic [HART_W-1:0] hart_idx;
    logic [31:0]       addr32, msip_idx, cmp_off, cmp_idx, rdata;
    logic [63:0]       cmp_vec [NUM_HARTS];

`ifdef CLINT_MTIME_HALT_EN
    assign halt = mtime_halt_i;
`else
    assign halt = 1'b0;
`endif

    assign addr32 = 32'(req_addr_i);
    assign accept = req_valid_i && req_ready_o;

    // Address decode; anything not landing on a mapped, aligned word stays SEL_NONE (error).
    always_comb begin
        sel      = SEL_NONE;
        hart_idx = '0;
        msip_idx = (addr32 - 32'(MSIP_BASE)) >> 2;
        cmp_off  = addr32 - 32'(MTIMECMP_BASE);
        cmp_idx  = cmp_off >> 3;
        if (addr32[1:0] == 2'b00) begin
            if (addr32 == 32'(MTIME_LO)) begin
                sel = SEL_MTIME_LO;
            end else if (addr32 == 32'(MTIME_HI)) begin
                sel = SEL_MTIME_HI;
            end else if (addr32 < 32'(MTIMECMP_BASE)) begin
                if (msip_idx < 32'(NUM_HARTS)) begin
                    sel      = SEL_MSIP;
                    hart_idx = msip_idx[HART_W-1:0];
                end
            end else if (addr32 < 32'(MTIME_LO)) begin
                if (cmp_idx < 32'(NUM_HARTS)) begin
                    sel      = cmp_off[2] ? SEL_CMP_HI : SEL_CMP_LO;
                    hart_idx = cmp_idx[HART_W-1:0];
                end
            end
        end
    end

    assign wr_ok = accept && req_write_i && (sel != SEL_NONE);

    // Read mux samples registers before this cycle's write/increment lands.
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_MTIME_LO: rdata = mtime_q[31:0];
            SEL_MTIME_HI: rdata = mtime_q[63:32];
            default: begin
                for (int h = 0; h < int'(NUM_HARTS); h++) begin
                    if (hart_idx == HART_W'(h)) begin
                        if (sel == SEL_MSIP)   rdata = {31'b0, msip_o[h]};
                        if (sel == SEL_CMP_LO) rdata = cmp_vec[h][31:0];
                        if (sel == SEL_CMP_HI) rdata = cmp_vec[h][63:32];
                    end
                end
            end
        endcase
    end

    // mtime/prescaler: a bus write to either half wins over the tick and restarts the prescaler.
    always_comb begin
        mtime_d = mtime_q;
        pre_d   = pre_q;
        if (wr_ok && sel == SEL_MTIME_LO) begin
            mtime_d[31:0] = req_wdata_i;
            pre_d         = '0;
        end else if (wr_ok && sel == SEL_MTIME_HI) begin
            mtime_d[63:32] = req_wdata_i;
            pre_d          = '0;
        end else if (!halt) begin
            if (pre_q == PRE_MAX) begin
                pre_d   = '0;
                mtime_d = mtime_q + 64'd1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // Response payload is captured on accept and held until the next accept.
    always_comb begin
        rsp_d = rsp_q;
        if (accept) begin
            rsp_d.err   = (sel == SEL_NONE);
            rsp_d.rdata = (!req_write_i && sel != SEL_NONE) ? rdata : 32'h0;
        end
    end

    // Bus FSM: state register / next state / outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUS_IDLE;
            rsp_q   <= '0;
            mtime_q <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            mtime_q <= mtime_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (accept) state_d = BUS_RSP;
            BUS_RSP: begin
                if (accept)           state_d = BUS_RSP;
                else if (rsp_ready_i) state_d = BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid_o = (state_q == BUS_RSP);
        req_ready_o = (state_q != BUS_RSP) || rsp_ready_i;
    end

    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;
    assign mtime_o     = mtime_q;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic hit;
        assign hit = wr_ok && (hart_idx == HART_W'(h));
        clint_hart_cmp u_cmp (
            .clk        (clk),
            .rst        (rst),
            .wr_msip_i  (hit && sel == SEL_MSIP),
            .wr_cmp_lo_i(hit && sel == SEL_CMP_LO),
            .wr_cmp_hi_i(hit && sel == SEL_CMP_HI),
            .wdata_i    (req_wdata_i),
            .mtime_i    (mtime_q),
            .mtimecmp_o (cmp_vec[h]),
            .msip_o     (msip_o[h]),
            .mtip_o     (mtip_o[h])
        );
    end

endmodule

// File: tb/tb_clint_mtimer.sv
// tb_clint_mtimer: directed bench for clint_mtimer with a response scoreboard.
// Instance A: 2 harts, tick every cycle. Instance B: 1 hart, tick every 4th cycle.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_clint_mtimer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_req_valid, a_req_write, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [15:0] a_req_addr;
    logic [31:0] a_req_wdata, a_rsp_rdata;
    logic [1:0]  a_mtip, a_msip;
    logic [63:0] a_mtime;

    logic        b_req_valid, b_req_write, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [15:0] b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_rdata;
    logic [0:0]  b_mtip, b_msip;
    logic [63:0] b_mtime;

    clint_mtimer #(.NUM_HARTS(2), .TICK_DIV(1), .ADDR_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata),
        .rsp_err_o(a_rsp_err),
`ifdef CLINT_MTIME_HALT_EN
        .mtime_halt_i(1'b0),
`endif
        .mtip_o(a_mtip), .msip_o(a_msip), .mtime_o(a_mtime)
    );

    clint_mtimer #(.NUM_HARTS(1), .TICK_DIV(4), .ADDR_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
        .rsp_err_o(b_rsp_err),
`ifdef CLINT_MTIME_HALT_EN
        .mtime_halt_i(1'b0),
`endif
        .mtip_o(b_mtip), .msip_o(b_msip), .mtime_o(b_mtime)
    );

    // Response view of whichever instance the current step talks to.
    bit          use_b;
    logic        m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;
    assign m_rsp_valid = use_b ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_err   = use_b ? b_rsp_err   : a_rsp_err;
    assign m_rsp_rdata = use_b ? b_rsp_rdata : a_rsp_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];   // {err, rdata}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic collect();
        int          n;
        logic [32:0] e;
        n = 0;
        while (!m_rsp_valid && n < 8) begin
            step();
            n++;
        end
        chk("rsp_valid", 64'(m_rsp_valid), 64'd1);
        if (m_rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_err", 64'(m_rsp_err), 64'(e[32]));
            chk("rsp_rdata", 64'(m_rsp_rdata), 64'(e[31:0]));
        end
    endtask

    task automatic drive(input bit vld, input bit wr, input logic [15:0] addr, input logic [31:0] wd);
        if (use_b) begin
            b_req_valid = vld; b_req_write = wr; b_req_addr = addr; b_req_wdata = wd;
        end else begin
            a_req_valid = vld; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd;
        end
    endtask

    // One back-to-back transaction: consumes exactly one clock when the bus is free.
    task automatic do_req(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_d, input bit exp_e);
        exp_q.push_back({exp_e, exp_d});
        drive(1'b1, wr, addr, wd);
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        collect();
    endtask

    initial begin
        rst = 1'b1; use_b = 1'b0;
        a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1;
        b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1;
        repeat (3) step();

        chk("rst_mtime_a", a_mtime, 64'd0);
        chk("rst_mtip_a", 64'(a_mtip), 64'd0);
        chk("rst_msip_a", 64'(a_msip), 64'd0);
        chk("rst_rsp_valid_a", 64'(a_rsp_valid), 64'd0);
        chk("rst_rdata_a", 64'(a_rsp_rdata), 64'd0);
        chk("rst_err_a", 64'(a_rsp_err), 64'd0);
        chk("rst_req_ready_a", 64'(a_req_ready), 64'd1);
        chk("rst_req_ready_b", 64'(b_req_ready), 64'd1);
        chk("rst_mtime_b", b_mtime, 64'd0);
        chk("rst_mtip_b", 64'(b_mtip), 64'd0);
        chk("rst_msip_b", 64'(b_msip), 64'd0);

        // Free-running count: A every cycle, B every 4th cycle.
        rst = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            chk("count_a", a_mtime, 64'(k));
            chk("count_b", b_mtime, 64'(k / 4));
            step();
        end

        // Reset values through the bus, then unmapped / misaligned accesses.
        do_req(1'b0, 16'h4000, 32'h0, 32'hFFFF_FFFF, 1'b0);
        do_req(1'b0, 16'h4004, 32'h0, 32'hFFFF_FFFF, 1'b0);
        do_req(1'b0, 16'h400C, 32'h0, 32'hFFFF_FFFF, 1'b0);
        do_req(1'b0, 16'h0008, 32'h0, 32'h0, 1'b1);
        do_req(1'b0, 16'h0002, 32'h0, 32'h0, 1'b1);
        do_req(1'b0, 16'h4010, 32'h0, 32'h0, 1'b1);
        do_req(1'b0, 16'hBFF4, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 16'h0008, 32'h1, 32'h0, 1'b1);
        chk("err_write_no_effect", 64'(a_msip), 64'd0);

        // msip set/read/clear; only bit0 is stored.
        do_req(1'b1, 16'h0004, 32'h1, 32'h0, 1'b0);
        chk("msip_set", 64'(a_msip), 64'b10);
        do_req(1'b0, 16'h0004, 32'h0, 32'h1, 1'b0);
        do_req(1'b0, 16'h0000, 32'h0, 32'h0, 1'b0);
        do_req(1'b1, 16'h0004, 32'hFFFF_FFFE, 32'h0, 1'b0);
        chk("msip_clr", 64'(a_msip), 64'd0);

        // Prescaler restart on mtime write (instance B).
        use_b = 1'b1;
        do_req(1'b1, 16'hBFF8, 32'h10, 32'h0, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            chk("presc_b", b_mtime, 64'h10 + 64'(k / 4));
            step();
        end
        do_req(1'b0, 16'hBFF8, 32'h0, 32'h11, 1'b0);
        use_b = 1'b0;

        // mtip for hart 1 at mtimecmp = 0x20; hart 0 stays at all-ones.
        do_req(1'b1, 16'hBFFC, 32'h0, 32'h0, 1'b0);
        do_req(1'b1, 16'hBFF8, 32'h0, 32'h0, 1'b0);
        chk("mtime_wr_lo", a_mtime, 64'd0);
        do_req(1'b1, 16'h4008, 32'h20, 32'h0, 1'b0);
        do_req(1'b1, 16'h400C, 32'h0, 32'h0, 1'b0);
        for (int k = 2; k <= 40; k++) begin
            chk("mtip_mtime", a_mtime, 64'(k));
            chk("mtip1", 64'(a_mtip[1]), 64'((k - 1) >= 32));
            chk("mtip0", 64'(a_mtip[0]), 64'd0);
            step();
        end
        // Raising mtimecmp clears the level one cycle after the write lands.
        do_req(1'b1, 16'h400C, 32'h1, 32'h0, 1'b0);
        chk("mtip1_lag", 64'(a_mtip[1]), 64'd1);
        step();
        chk("mtip1_clr", 64'(a_mtip[1]), 64'd0);

        // lo -> hi carry.
        do_req(1'b1, 16'hBFFC, 32'h0, 32'h0, 1'b0);
        do_req(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 32'h0, 1'b0);
        chk("carry_pre", a_mtime, 64'h0000_0000_FFFF_FFFF);
        step();
        chk("carry_hi", a_mtime, 64'h0000_0001_0000_0000);

        // 64-bit wrap; hart 0 (mtimecmp all-ones) fires exactly once.
        do_req(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 32'h0, 1'b0);
        do_req(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 32'h0, 1'b0);
        chk("wrap_t0", a_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        chk("wrap_t1", a_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_mtip0_t1", 64'(a_mtip[0]), 64'd0);
        step();
        chk("wrap_t2", a_mtime, 64'd0);
        chk("wrap_mtip0_t2", 64'(a_mtip[0]), 64'd1);
        step();
        chk("wrap_mtip0_t3", 64'(a_mtip[0]), 64'd0);
        do_req(1'b0, 16'hBFFC, 32'h0, 32'h0, 1'b0);

        // Response backpressure for 3 cycles; a second request waits.
        step();
        a_rsp_ready = 1'b0;
        exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        drive(1'b1, 1'b0, 16'h4000, 32'h0);
        chk("bp_ready_idle", 64'(a_req_ready), 64'd1);
        step();
        exp_q.push_back({1'b1, 32'h0});
        drive(1'b1, 1'b0, 16'h0008, 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 64'(a_rsp_valid), 64'd1);
            chk("bp_rdata", 64'(a_rsp_rdata), 64'(exp_q[0][31:0]));
            chk("bp_err", 64'(a_rsp_err), 64'(exp_q[0][32]));
            chk("bp_req_ready", 64'(a_req_ready), 64'd0);
            if (k < 2) step();
        end
        a_rsp_ready = 1'b1;
        void'(exp_q.pop_front());
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        collect();

        // Reset while a response is pending drops it.
        step();
        a_rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 16'h0000, 32'h1);
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        chk("pend_valid", 64'(a_rsp_valid), 64'd1);
        chk("pend_msip", 64'(a_msip), 64'b01);
        rst = 1'b1;
        step();
        chk("rst_drop_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_drop_msip", 64'(a_msip), 64'd0);
        chk("rst_drop_mtime", a_mtime, 64'd0);
        chk("rst_drop_mtip", 64'(a_mtip), 64'd0);
        rst = 1'b0;
        a_rsp_ready = 1'b1;
        step();
        chk("rst_no_rsp", 64'(a_rsp_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
